// File: rtl/connect4_pkg.sv
// Shared Connect4 definitions: turn-FSM state codes, game status codes, cell codes,
// board geometry defaults and line-direction deltas.
package connect4_pkg;

   // Board geometry defaults
   localparam int unsigned ROWS_DEF    = 6;
   localparam int unsigned COLS_DEF    = 7;
   localparam int unsigned WIN_LEN_DEF = 4;

   // Turn FSM current_state codes
   localparam logic [1:0] FSM_INIT    = 2'b00;
   localparam logic [1:0] FSM_P1_TURN = 2'b01;
   localparam logic [1:0] FSM_P2_TURN = 2'b10;
   localparam logic [1:0] FSM_END     = 2'b11;

   // game_status codes
   localparam logic [1:0] NEXT_TURN  = 2'b00;
   localparam logic [1:0] PLAYER_WIN = 2'b01;
   localparam logic [1:0] TIE_GAME   = 2'b10;

   // Display cell codes
   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   // Line directions in scan order: horizontal, vertical, diagonal /, diagonal \.
   // Each entry is the (row, column) step of the positive sense.
   localparam int NUM_DIRS = 4;
   localparam int DIR_DR [NUM_DIRS] = '{0, 1, 1, 1};
   localparam int DIR_DC [NUM_DIRS] = '{1, 0, 1, -1};

endpackage

// File: rtl/win_scanner.sv
// Multi-cycle win scanner: walks the four line directions through a newly placed piece,
// one cell per cycle, and reports whether any line reaches the winning run length.
module win_scanner
   import connect4_pkg::*;
#(
   parameter int unsigned ROWS    = ROWS_DEF,
   parameter int unsigned COLS    = COLS_DEF,
   parameter int unsigned WIN_LEN = WIN_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           org_row,
   input  logic [2:0]           org_col,
   input  logic                 color,
   input  logic [ROWS*COLS-1:0] occ,
   input  logic [ROWS*COLS-1:0] own,
   output logic                 done,
   output logic                 win
);

   localparam int unsigned NCELL = ROWS * COLS;
   localparam int unsigned IW    = $clog2(NCELL);
   localparam int unsigned CW    = $clog2(WIN_LEN) + 1;
   localparam logic [CW-1:0] NEED = CW'(WIN_LEN - 1);

   logic          active_q, active_d;
   logic [2:0]    sense_q, sense_d;  // {direction, negative sense}
   logic [CW-1:0] step_q, step_d;    // distance of the cell under test from the origin
   logic [CW-1:0] cnt_q, cnt_d;      // matches so far in the current direction
   logic [2:0]    row_q, row_d;
   logic [2:0]    col_q, col_d;
   logic          color_q, color_d;

   int            cur_r, cur_c;
   logic [IW-1:0] cur_idx;
   logic          match;
   logic [CW-1:0] cnt_inc, cnt_keep;
   logic [3:0]    nxt;

   function automatic logic on_board(input int r, input int c);
      return (r >= 0) && (r < int'(ROWS)) && (c >= 0) && (c < int'(COLS));
   endfunction

   function automatic int sense_row(input logic [2:0] s, input int k, input int r0);
      return s[0] ? r0 - k * DIR_DR[s[2:1]] : r0 + k * DIR_DR[s[2:1]];
   endfunction

   function automatic int sense_col(input logic [2:0] s, input int k, input int c0);
      return s[0] ? c0 - k * DIR_DC[s[2:1]] : c0 + k * DIR_DC[s[2:1]];
   endfunction

   // Lowest sense >= from whose first cell is on the board; bit 3 flags that one exists.
   // Senses starting off-board are skipped here so they cost no cycles.
   function automatic logic [3:0] find_sense(input int from, input int r0, input int c0);
      logic [3:0] res;
      res = 4'b0000;
      for (int s = 7; s >= 0; s--) begin
         if (s >= from && on_board(sense_row(3'(s), 1, r0), sense_col(3'(s), 1, c0)))
            res = {1'b1, 3'(s)};
      end
      return res;
   endfunction

   // Examine one cell per cycle and decide whether to step, switch sense or finish
   always_comb begin
      active_d = active_q;
      sense_d  = sense_q;
      step_d   = step_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      col_d    = col_q;
      color_d  = color_q;
      done     = 1'b0;
      win      = 1'b0;
      cnt_keep = cnt_q;
      nxt      = 4'b0000;

      cur_r   = sense_row(sense_q, int'(step_q), int'(row_q));
      cur_c   = sense_col(sense_q, int'(step_q), int'(col_q));
      cur_idx = IW'(cur_r * int'(COLS) + cur_c);
      match   = 1'b0;
      if (on_board(cur_r, cur_c))
         match = occ[cur_idx] && (own[cur_idx] == color_q);
      cnt_inc = cnt_q + CW'(1);

      if (start) begin
         row_d    = org_row;
         col_d    = org_col;
         color_d  = color;
         nxt      = find_sense(0, int'(org_row), int'(org_col));
         active_d = nxt[3];
         sense_d  = nxt[2:0];
         step_d   = CW'(1);
         cnt_d    = '0;
      end else if (active_q) begin
         if (match && cnt_inc >= NEED) begin
            done     = 1'b1;
            win      = 1'b1;
            active_d = 1'b0;
         end else if (match && on_board(sense_row(sense_q, int'(step_q) + 1, int'(row_q)),
                                        sense_col(sense_q, int'(step_q) + 1, int'(col_q)))) begin
            step_d = step_q + CW'(1);
            cnt_d  = cnt_inc;
         end else begin
            cnt_keep = match ? cnt_inc : cnt_q;
            nxt      = find_sense(int'(sense_q) + 1, int'(row_q), int'(col_q));
            if (nxt[3]) begin
               sense_d = nxt[2:0];
               step_d  = CW'(1);
               // The negative sense keeps the positive sense's count; a new direction restarts
               cnt_d   = (nxt[2:1] == sense_q[2:1]) ? cnt_keep : '0;
            end else begin
               done     = 1'b1;
               active_d = 1'b0;
            end
         end
      end
   end

   // Scanner state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q <= 1'b0;
         sense_q  <= '0;
         step_q   <= '0;
         cnt_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         color_q  <= 1'b0;
      end else begin
         active_q <= active_d;
         sense_q  <= sense_d;
         step_q   <= step_d;
         cnt_q    <= cnt_d;
         row_q    <= row_d;
         col_q    <= col_d;
         color_q  <= color_d;
      end
   end

endmodule

// File: rtl/board_engine.sv
// Connect4 board datapath and move evaluator: stores the grid, places dropped pieces,
// runs the win scan and reports the move outcome to the turn FSM.
module board_engine
   import connect4_pkg::*;
#(
   parameter int unsigned ROWS    = ROWS_DEF,
   parameter int unsigned COLS    = COLS_DEF,
   parameter int unsigned WIN_LEN = WIN_LEN_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       drop,
   input  logic [2:0] column,
   input  logic [1:0] fsm_state,
   input  logic [2:0] rd_row,
   input  logic [2:0] rd_col,
   output logic [1:0] rd_cell,
   output logic       invalid_column,
   output logic [1:0] game_status,
   output logic       player_turn,
   output logic       busy,
   output logic       drop_err
);

   localparam int unsigned NCELL     = ROWS * COLS;
   localparam int unsigned IW        = $clog2(NCELL);
   localparam logic [5:0]  MAX_MOVES = 6'(NCELL);

   localparam logic [2:0] E_IDLE   = 3'd0;
   localparam logic [2:0] E_PLACE  = 3'd1;
   localparam logic [2:0] E_CHECK  = 3'd2;
   localparam logic [2:0] E_REPORT = 3'd3;
   localparam logic [2:0] E_DONE   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [NCELL-1:0] occ_q, own_q;
   logic [2:0]       height_q [COLS];
   logic [5:0]       moves_q;
   logic [2:0]       row_q, row_d;
   logic [2:0]       col_q, col_d;
   logic             color_q, color_d;
   logic [1:0]       status_q, status_d;
   logic             player_turn_q;
   logic             drop_err_q, drop_err_d;

   logic [2:0]       sel_height;
   logic             turn_ok, col_ok, reporting;
   logic             scan_start, scan_done, scan_win;
   logic [IW-1:0]    place_idx, rd_idx;

   assign turn_ok   = (fsm_state == FSM_P1_TURN) || (fsm_state == FSM_P2_TURN);
   assign col_ok    = int'(column) < int'(COLS);
   assign place_idx = IW'(int'(row_q) * int'(COLS) + int'(col_q));

   // Height of the requested column; out-of-range columns read as 0 and are rejected anyway
   always_comb begin
      sel_height = '0;
      for (int c = 0; c < int'(COLS); c++) begin
         if (int'(column) == c) sel_height = height_q[c];
      end
   end

   // Top-level move sequencing
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      color_d    = color_q;
      status_d   = status_q;
      drop_err_d = 1'b0;
      scan_start = 1'b0;
      case (state_q)
         E_IDLE: begin
            if (drop && turn_ok) begin
               if (!col_ok || sel_height == 3'(ROWS)) begin
                  drop_err_d = 1'b1;
               end else begin
                  state_d = E_PLACE;
                  row_d   = sel_height;
                  col_d   = column;
                  color_d = fsm_state[1];
               end
            end
         end
         E_PLACE: begin
            state_d    = E_CHECK;
            scan_start = 1'b1;
         end
         E_CHECK: begin
            if (scan_done) begin
               state_d = E_REPORT;
               // A win on the last free cell still reports as a win
               if (scan_win)                   status_d = PLAYER_WIN;
               else if (moves_q == MAX_MOVES) status_d = TIE_GAME;
               else                            status_d = NEXT_TURN;
            end
         end
         E_REPORT: state_d = (status_q == NEXT_TURN) ? E_IDLE : E_DONE;
         E_DONE:   state_d = E_DONE;
         default:  state_d = E_IDLE;
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= E_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         color_q    <= 1'b0;
         status_q   <= NEXT_TURN;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         color_q    <= color_d;
         status_q   <= status_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Board storage: the piece, column height and move count all update in PLACE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q         <= '0;
         own_q         <= '0;
         moves_q       <= '0;
         player_turn_q <= 1'b0;
         for (int c = 0; c < int'(COLS); c++) height_q[c] <= '0;
      end else if (state_q == E_PLACE) begin
         occ_q[place_idx] <= 1'b1;
         own_q[place_idx] <= color_q;
         moves_q          <= moves_q + 6'd1;
         player_turn_q    <= color_q;
         for (int c = 0; c < int'(COLS); c++) begin
            if (int'(col_q) == c) height_q[c] <= height_q[c] + 3'd1;
         end
      end
   end

   win_scanner #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .WIN_LEN (WIN_LEN)
   ) u_scanner (
      .clk     (clk),
      .reset   (reset),
      .start   (scan_start),
      .org_row (row_q),
      .org_col (col_q),
      .color   (color_q),
      .occ     (occ_q),
      .own     (own_q),
      .done    (scan_done),
      .win     (scan_win)
   );

   // Combinational display read port
   always_comb begin
      rd_idx  = IW'(int'(rd_row) * int'(COLS) + int'(rd_col));
      rd_cell = CELL_EMPTY;
      if (int'(rd_row) < int'(ROWS) && int'(rd_col) < int'(COLS)) begin
         if (occ_q[rd_idx]) rd_cell = own_q[rd_idx] ? CELL_P2 : CELL_P1;
      end
   end

   // FSM-facing outputs
   assign reporting      = (state_q == E_REPORT) || (state_q == E_DONE);
   assign invalid_column = !reporting;
   assign game_status    = reporting ? status_q : NEXT_TURN;
   assign busy           = (state_q == E_PLACE) || (state_q == E_CHECK) || (state_q == E_REPORT);
   assign player_turn    = player_turn_q;
   assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: directed scenarios plus random games, all checked
// against a board-level reference model kept in the bench.
module tb_board_engine;

   localparam int ROWS = 6;
   localparam int COLS = 7;

   logic       clk;
   logic       reset;
   logic       drop;
   logic [2:0] column;
   logic [1:0] fsm_state;
   logic [2:0] rd_row;
   logic [2:0] rd_col;
   logic [1:0] rd_cell;
   logic       invalid_column;
   logic [1:0] game_status;
   logic       player_turn;
   logic       busy;
   logic       drop_err;

   board_engine dut (
      .clk            (clk),
      .reset          (reset),
      .drop           (drop),
      .column         (column),
      .fsm_state      (fsm_state),
      .rd_row         (rd_row),
      .rd_col         (rd_col),
      .rd_cell        (rd_cell),
      .invalid_column (invalid_column),
      .game_status    (game_status),
      .player_turn    (player_turn),
      .busy           (busy),
      .drop_err       (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model: 0 empty, 1 P1, 2 P2
   int bd [ROWS][COLS];
   int ht [COLS];
   int moves;
   int model_over;
   int model_status;

   int turn;
   logic [1:0] fs;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Any straight run of four cells of this player anywhere on the board
   function automatic bit model_win(input int who);
      int dr, dc, rr, cc;
      bit ok;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int d = 0; d < 4; d++) begin
               dr = (d == 0) ? 0 : 1;
               dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
               ok = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  rr = r + k * dr;
                  cc = c + k * dc;
                  if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
                  else if (bd[rr][cc] != who) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   task automatic clear_model();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) bd[r][c] = 0;
      for (int c = 0; c < COLS; c++) ht[c] = 0;
      moves        = 0;
      model_over   = 0;
      model_status = 0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      drop      = 1'b0;
      column    = 3'd0;
      fsm_state = 2'b00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_model();
      @(negedge clk);
   endtask

   task automatic check_board(input string tag);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            rd_row = 3'(r);
            rd_col = 3'(c);
            #1 check(tag, int'(rd_cell), bd[r][c]);
         end
      rd_row = 3'd6; rd_col = 3'd0;
      #1 check({tag, "_row_oob"}, int'(rd_cell), 0);
      rd_row = 3'd0; rd_col = 3'd7;
      #1 check({tag, "_col_oob"}, int'(rd_cell), 0);
   endtask

   // One drop request; every outcome (ignored, rejected, accepted) is checked against the model
   task automatic do_drop(input int col, input logic [1:0] f);
      bit ign, acc, found;
      int r, k, exp_st;
      ign = (model_over != 0) || !(f == 2'b01 || f == 2'b10);
      acc = !ign && col < COLS && ht[col] < ROWS;
      @(negedge clk);
      fsm_state = f;
      drop      = 1'b1;
      column    = 3'(col);
      @(negedge clk);
      drop = 1'b0;
      if (!acc) begin
         check("drop_err_rise", int'(drop_err), ign ? 0 : 1);
         check("busy_no_move", int'(busy), 0);
         check("invalid_no_move", int'(invalid_column), (model_over != 0) ? 0 : 1);
         check("status_no_move", int'(game_status), model_status);
         @(negedge clk);
         check("drop_err_fall", int'(drop_err), 0);
         return;
      end
      r = ht[col];
      bd[r][col] = f[1] ? 2 : 1;
      ht[col]++;
      moves++;
      exp_st = model_win(bd[r][col]) ? 1 : ((moves == ROWS * COLS) ? 2 : 0);
      check("busy_place", int'(busy), 1);
      found = 1'b0;
      k = 1;
      while (!found && k <= 40) begin
         if (invalid_column == 1'b0) found = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check("report_seen", int'(found), 1);
      check("report_latency", (k <= 26) ? 1 : 0, 1);
      check("report_status", int'(game_status), exp_st);
      check("player_turn", int'(player_turn), f[1] ? 1 : 0);
      rd_row = 3'(r);
      rd_col = 3'(col);
      #1 check("rd_cell_new", int'(rd_cell), bd[r][col]);
      @(negedge clk);
      if (exp_st == 0) begin
         check("single_report", int'(invalid_column), 1);
      end else begin
         model_over   = 1;
         model_status = exp_st;
         check("done_invalid", int'(invalid_column), 0);
         check("done_status", int'(game_status), exp_st);
         fsm_state = 2'b11;
      end
   endtask

   function automatic logic [1:0] tie_fs(input int r, input int c);
      return (((r / 2) + c) % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   initial begin
      rd_row = 3'd0;
      rd_col = 3'd0;
      turn   = 1;
      fs     = 2'b01;

      // Reset values
      do_reset();
      check("rst_invalid", int'(invalid_column), 1);
      check("rst_status", int'(game_status), 0);
      check("rst_turn", int'(player_turn), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_drop_err", int'(drop_err), 0);
      check_board("rst_board");

      // First move, then fill column 0 and overflow it, then an out-of-range column
      do_drop(3, 2'b01);
      for (int i = 0; i < 6; i++) do_drop(0, (i % 2 == 0) ? 2'b10 : 2'b01);
      do_drop(0, 2'b10);
      check_board("full_col_board");
      do_drop(7, 2'b10);
      do_drop(1, 2'b00);
      check_board("oob_board");

      // Horizontal P1 win on the seventh move; DONE holds and ignores drops
      do_reset();
      begin
         int seq [7] = '{0, 6, 1, 6, 2, 6, 3};
         for (int i = 0; i < 7; i++) do_drop(seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      check("hwin_status", int'(game_status), 1);
      repeat (3) @(negedge clk);
      check("hwin_hold_invalid", int'(invalid_column), 0);
      check("hwin_hold_status", int'(game_status), 1);
      do_drop(4, 2'b01);
      check_board("hwin_board");

      // Diagonal / for P2 completed at its second cell (1,2)
      do_reset();
      begin
         int seq [12] = '{2, 1, 3, 3, 4, 3, 4, 6, 4, 4, 6, 2};
         for (int i = 0; i < 12; i++) do_drop(seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      check("diag_status", int'(game_status), 1);
      check("diag_turn", int'(player_turn), 1);

      // Full board with no run of four: tie on the 42nd move
      do_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) do_drop(c, tie_fs(r, c));
      check("tie_status", int'(game_status), 2);
      check_board("tie_board");

      // Same fill with two top-row cells flipped so the 42nd move completes a row
      do_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            fs = tie_fs(r, c);
            if (r == 5 && (c == 4 || c == 6)) fs = ~fs;
            do_drop(c, fs);
         end
      check("last_win_status", int'(game_status), 1);

      // Reset asserted while the scan is running
      do_reset();
      do_drop(2, 2'b01);
      @(negedge clk);
      fsm_state = 2'b10;
      drop      = 1'b1;
      column    = 3'd2;
      @(negedge clk);
      drop = 1'b0;
      check("midck_place_busy", int'(busy), 1);
      @(negedge clk);
      check("midck_check_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("midck_invalid", int'(invalid_column), 1);
      check("midck_status", int'(game_status), 0);
      check("midck_turn", int'(player_turn), 0);
      check("midck_busy", int'(busy), 0);
      check("midck_drop_err", int'(drop_err), 0);
      clear_model();
      @(negedge clk);
      reset = 1'b0;
      check_board("midck_board");

      // Random games against the model
      for (int g = 0; g < 4; g++) begin
         do_reset();
         turn = 1;
         for (int m = 0; m < 70 && model_over == 0; m++) begin
            int col, prev;
            fs   = ($urandom_range(0, 9) == 0) ? 2'b00 : ((turn == 1) ? 2'b01 : 2'b10);
            col  = $urandom_range(0, 7);
            prev = moves;
            do_drop(col, fs);
            if (moves != prev) turn = 3 - turn;
         end
         check_board("rand_board");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/board_engine.md
# board_engine

Game-board datapath and move evaluator for Connect4, sitting directly upstream of the turn FSM. Accepts column drop requests, stores the 6x7 grid, places the piece in the lowest free row, and scans the four line directions through the new piece over several cycles. It then drives the FSM's `invalid_column` and `in_game_status` inputs and serves a combinational cell read port to the display logic.

## Interface
- `ROWS`, 6: board rows; row 0 is the bottom.
- `COLS`, 7: board columns.
- `WIN_LEN`, 4: run length that wins.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `drop`  in  1  single-cycle drop request.
- `column`  in  3  target column, sampled with `drop`.
- `fsm_state`  in  2  FSM `current_state`: 00 INIT, 01 P1_TURN, 10 P2_TURN, 11 END.
- `rd_row`  in  3  display read row.
- `rd_col`  in  3  display read column.
- `rd_cell`  out  2  00 empty, 01 P1, 10 P2; combinational from `rd_row`/`rd_col`; 00 if out of range.
- `invalid_column`  out  1  to FSM; 1 = hold current turn.
- `game_status`  out  2  to FSM `in_game_status`: 00 NEXT_TURN, 01 PLAYER_WIN, 10 TIE_GAME.
- `player_turn`  out  1  owner of the last placed piece (0 = P1, 1 = P2).
- `busy`  out  1  move in evaluation; drops ignored.
- `drop_err`  out  1  one-cycle pulse on a rejected drop.

## Operation
- Storage:
  - `occ[ROWS*COLS]` and `own[ROWS*COLS]` bitmaps.
  - Per-column height counters, 3 bits each.
  - 6-bit move counter, range 0..42.
- States:
  - **IDLE**: wait for a drop.
  - **PLACE**: write the piece.
  - **CHECK**: scan directions.
  - **REPORT**: present the result to the FSM.
  - **DONE**: game over; terminal until reset.
- **IDLE** with `drop`=1 and `fsm_state` 01 or 10:
  - Reject if `column` ≥ COLS or `height[column]` = ROWS: pulse `drop_err` next cycle, board unchanged, stay in IDLE.
  - Otherwise latch `column`, `row` = `height[column]`, and `color` = `fsm_state`[1]; go to PLACE.
- `drop` is ignored in IDLE with `fsm_state` 00 or 11. It is ignored in PLACE, CHECK, REPORT and DONE, with no `drop_err`.
- **PLACE** (1 cycle):
  - Set `occ`/`own` at (`row`, `column`).
  - Increment `height[column]` and the move counter.
  - Set `player_turn` = `color`.
  - Go to CHECK.
- **CHECK**:
  - Directions in order: horizontal, vertical, diagonal /, diagonal \.
  - Each direction is walked + then −, one cell per cycle.
  - A sense stops at a board edge, an empty cell, or an opposite-color cell, and contributes 0 cycles if its first cell is off-board.
  - A sense also stops when the direction count reaches WIN_LEN−1.
  - Direction count = + matches plus − matches.
  - A win occurs when any direction count ≥ WIN_LEN−1. CHECK exits immediately on a win; otherwise it exits after the last direction.
- **REPORT** (1 cycle):
  - `invalid_column` = 0.
  - `game_status` = PLAYER_WIN if win; else TIE_GAME if the move counter = 42; else NEXT_TURN.
  - Win takes priority over tie on the 42nd move.
  - Next state is DONE on win or tie, else IDLE.
- **DONE**: hold `invalid_column` = 0 and the latched `game_status`.
- Outside REPORT and DONE: `invalid_column` = 1 and `game_status` = 00.
- `busy` = 1 in PLACE, CHECK and REPORT.

## Timing
- Reset values:
  - `invalid_column` = 1.
  - `game_status` = 00, `player_turn` = 0, `busy` = 0, `drop_err` = 0.
  - Bitmaps, heights and move counter cleared; state IDLE.
- Drop sampled at edge N:
  - PLACE is cycle N+1.
  - CHECK starts at N+2 and lasts 1–24 cycles (at most 3 cells per sense, 8 senses).
  - REPORT follows CHECK.
  - Worst-case drop-to-REPORT: 26 cycles.
- The FSM leaves P1_TURN/P2_TURN on the REPORT edge. The engine returns to IDLE the same edge and sees the new `fsm_state` on the next cycle.
- `drop_err` rises at edge N+1 for one cycle.
- Reset mid-move (any state) aborts the move: the board is cleared and there is no REPORT.
- `rd_cell` reflects a PLACE write from the cycle after the PLACE edge.

## Structure
- Shared package `connect4_pkg`, also used by the FSM:
  - FSM state codes.
  - `game_status` codes (NEXT_TURN/PLAYER_WIN/TIE_GAME).
  - Cell codes (EMPTY/P1/P2).
  - ROWS/COLS/WIN_LEN defaults.
  - Direction delta constants.
- One sub-module, `win_scanner`:
  - Inputs: start pulse, origin, color, the `occ`/`own` bitmaps.
  - Outputs: `done`, `win`.
  - Owns the direction/sense/step counters and the match counter.
- `board_engine` owns storage, heights, the top FSM and the output registers.

## Test plan
- P1 drops column 3 from reset → `rd_cell`(0,3) = 01; exactly one REPORT cycle with `invalid_column` = 0 and status 00; `player_turn` = 0.
- Six alternating drops into column 0, then a seventh → `drop_err` pulse; board and heights unchanged; `invalid_column` stays 1.
- Drop with `column` = 7 → `drop_err`; no move counted.
- P1 at columns 0,1,2,3 (row 0), P2 stacked on column 6 → PLAYER_WIN on the 7th move; DONE holds it; later drops ignored.
- Build a / diagonal for P2 at (0,1)(1,2)(2,3)(3,4), completing at the middle cell (1,2) → PLAYER_WIN.
- Fill all 42 cells with no run of 4 → TIE_GAME on the 42nd REPORT. Repeat with a 42nd move that completes a run → PLAYER_WIN.
- Assert `reset` during CHECK → all outputs return to reset values; board reads all 00.
